// File: rtl/atom_state_reader.sv
// Persistent state bank for the MAC stateful atoms with a single-outstanding
// control-plane snapshot reader (optional clear-on-read, write bypass at capture).

module atom_state_entry #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [COUNT_WIDTH-1:0] wr_data,
    input  logic                   clr,
    output logic [COUNT_WIDTH-1:0] value
);
    // Clear wins over a same-cycle write; the write value is reported via the bypass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        value <= '0;
        else if (clr)   value <= '0;
        else if (wr_en) value <= wr_data;
    end
endmodule

module atom_state_reader #(
    parameter int COUNT_WIDTH = 32,
    parameter int NUM_ENTRIES = 8,
    parameter int IDX_WIDTH   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i__wr_en,
    input  logic [IDX_WIDTH-1:0]   i__wr_idx,
    input  logic [COUNT_WIDTH-1:0] i__wr_data,
    input  logic [IDX_WIDTH-1:0]   i__dp_idx,
    output logic [COUNT_WIDTH-1:0] o__dp_read,
    input  logic                   i__rd_req_valid,
    output logic                   o__rd_req_ready,
    input  logic [IDX_WIDTH-1:0]   i__rd_idx,
    input  logic                   i__rd_clear,
    output logic                   o__rd_resp_valid,
    input  logic                   i__rd_resp_ready,
    output logic [COUNT_WIDTH-1:0] o__rd_resp_data,
    output logic [IDX_WIDTH-1:0]   o__rd_resp_idx,
    output logic                   o__rd_resp_err
);
    typedef enum logic [1:0] {IDLE, CAPTURE, RESP} state_t;

    typedef struct packed {
        logic [IDX_WIDTH-1:0] idx;
        logic                 clear;
        logic                 err;
    } rd_req_t;

    localparam logic [IDX_WIDTH:0] NUM_E = (IDX_WIDTH+1)'(NUM_ENTRIES);

    state_t  state, state_nxt;
    rd_req_t req_q;
    logic    rdy_q;
    logic    req_accept;
    logic    rd_err;

    logic [NUM_ENTRIES-1:0][COUNT_WIDTH-1:0] ent_val;
    logic [NUM_ENTRIES-1:0]                  ent_wr;
    logic [NUM_ENTRIES-1:0]                  ent_clr;
    logic [COUNT_WIDTH-1:0]                  snap;

    assign rd_err     = {1'b0, i__rd_idx} >= NUM_E;
    assign req_accept = (state == IDLE) && rdy_q && i__rd_req_valid;

    // Out-of-range write indices match no entry, so they drop out naturally.
    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_ent
        assign ent_wr[g]  = i__wr_en && (i__wr_idx == IDX_WIDTH'(g));
        assign ent_clr[g] = (state == CAPTURE) && req_q.clear && !req_q.err &&
                            (req_q.idx == IDX_WIDTH'(g));
        atom_state_entry #(.COUNT_WIDTH(COUNT_WIDTH)) u_ent (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (ent_wr[g]),
            .wr_data (i__wr_data),
            .clr     (ent_clr[g]),
            .value   (ent_val[g])
        );
    end

    always_comb begin
        o__dp_read = '0;
        for (int i = 0; i < NUM_ENTRIES; i++)
            if (i__dp_idx == IDX_WIDTH'(i)) o__dp_read = ent_val[i];
    end

    // Snapshot: stored value, overridden by a same-cycle write, forced to 0 on error.
    always_comb begin
        snap = '0;
        for (int i = 0; i < NUM_ENTRIES; i++)
            if (req_q.idx == IDX_WIDTH'(i)) snap = ent_val[i];
        if (i__wr_en && (i__wr_idx == req_q.idx)) snap = i__wr_data;
        if (req_q.err) snap = '0;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_accept) state_nxt = CAPTURE;
            CAPTURE: state_nxt = RESP;
            RESP:    if (i__rd_resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rdy_q <= 1'b0;
            req_q <= '0;
        end else begin
            state <= state_nxt;
            rdy_q <= (state_nxt == IDLE);
            if (req_accept) req_q <= '{idx: i__rd_idx, clear: i__rd_clear, err: rd_err};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o__rd_resp_valid <= 1'b0;
            o__rd_resp_data  <= '0;
            o__rd_resp_idx   <= '0;
            o__rd_resp_err   <= 1'b0;
        end else if (state == CAPTURE) begin
            o__rd_resp_valid <= 1'b1;
            o__rd_resp_data  <= snap;
            o__rd_resp_idx   <= req_q.idx;
            o__rd_resp_err   <= req_q.err;
        end else if (state == RESP && i__rd_resp_ready) begin
            o__rd_resp_valid <= 1'b0;
        end
    end

    assign o__rd_req_ready = rdy_q;
endmodule

// File: tb/tb_atom_state_reader.sv
// Scoreboard bench for atom_state_reader: behavioural entry model, queued
// expected responses, negedge monitor comparing responses, ready and dp reads.

module tb_atom_state_reader;
    localparam int W  = 32;
    localparam int N  = 6;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          i__wr_en;
    logic [IW-1:0] i__wr_idx;
    logic [W-1:0]  i__wr_data;
    logic [IW-1:0] i__dp_idx;
    logic [W-1:0]  o__dp_read;
    logic          i__rd_req_valid;
    logic          o__rd_req_ready;
    logic [IW-1:0] i__rd_idx;
    logic          i__rd_clear;
    logic          o__rd_resp_valid;
    logic          i__rd_resp_ready;
    logic [W-1:0]  o__rd_resp_data;
    logic [IW-1:0] o__rd_resp_idx;
    logic          o__rd_resp_err;

    atom_state_reader #(.COUNT_WIDTH(W), .NUM_ENTRIES(N), .IDX_WIDTH(IW)) dut (
        .clk(clk), .rst(rst),
        .i__wr_en(i__wr_en), .i__wr_idx(i__wr_idx), .i__wr_data(i__wr_data),
        .i__dp_idx(i__dp_idx), .o__dp_read(o__dp_read),
        .i__rd_req_valid(i__rd_req_valid), .o__rd_req_ready(o__rd_req_ready),
        .i__rd_idx(i__rd_idx), .i__rd_clear(i__rd_clear),
        .o__rd_resp_valid(o__rd_resp_valid), .i__rd_resp_ready(i__rd_resp_ready),
        .o__rd_resp_data(o__rd_resp_data), .o__rd_resp_idx(o__rd_resp_idx),
        .o__rd_resp_err(o__rd_resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  data;
        logic [IW-1:0] idx;
        logic          err;
    } resp_t;

    resp_t         q[$];
    logic [W-1:0]  mdl [N];
    int            phase = 0;
    logic          ready_exp = 1'b0;
    int            lat_idx;
    logic          lat_clr, lat_err;
    int            n_chk = 0, n_fail = 0;
    int            bg_mode = 0;
    logic [W-1:0]  last_data;
    logic          last_err;
    logic [IW-1:0] last_idx;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: entries as a plain array, a read as three abstract phases.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < N; i++) mdl[i] = '0;
            q.delete();
            phase = 0;
            ready_exp = 1'b0;
        end else begin
            logic         clr_now;
            logic [W-1:0] s;
            clr_now = 1'b0;
            case (phase)
                0: if (ready_exp && i__rd_req_valid) begin
                    lat_idx = int'(i__rd_idx);
                    lat_clr = i__rd_clear;
                    lat_err = (lat_idx >= N);
                    phase = 1;
                end
                1: begin
                    if (lat_err) s = '0;
                    else if (i__wr_en && int'(i__wr_idx) == lat_idx) s = i__wr_data;
                    else s = mdl[lat_idx];
                    q.push_back('{s, IW'(lat_idx), lat_err});
                    clr_now = lat_clr && !lat_err;
                    phase = 2;
                end
                default: if (i__rd_resp_ready) phase = 0;
            endcase
            if (i__wr_en && int'(i__wr_idx) < N) mdl[i__wr_idx] = i__wr_data;
            if (clr_now) mdl[lat_idx] = '0;
            ready_exp = (phase == 0);
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            logic [W-1:0] dexp;
            chk("req_ready", 64'(o__rd_req_ready), 64'(ready_exp));
            chk("resp_valid", 64'(o__rd_resp_valid), 64'(phase == 2));
            if (o__rd_resp_valid) begin
                if (q.size() == 0) begin
                    chk("resp_unexpected", 64'(o__rd_resp_valid), 64'd0);
                end else begin
                    chk("resp_data", 64'(o__rd_resp_data), 64'(q[0].data));
                    chk("resp_idx", 64'(o__rd_resp_idx), 64'(q[0].idx));
                    chk("resp_err", 64'(o__rd_resp_err), 64'(q[0].err));
                    if (i__rd_resp_ready) begin
                        last_data = o__rd_resp_data;
                        last_err  = o__rd_resp_err;
                        last_idx  = o__rd_resp_idx;
                        void'(q.pop_front());
                    end
                end
            end
            dexp = (int'(i__dp_idx) < N) ? mdl[i__dp_idx] : '0;
            chk("dp_read", 64'(o__dp_read), 64'(dexp));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        i__dp_idx = IW'($urandom_range(0, 7));
        case (bg_mode)
            1: begin
                i__wr_en   = $urandom_range(0, 1) == 1;
                i__wr_idx  = IW'($urandom_range(0, 7));
                i__wr_data = $urandom;
            end
            2: begin
                i__wr_en   = 1'b1;
                i__wr_idx  = 3'd1;
                i__wr_data = $urandom;
            end
            default: i__wr_en = 1'b0;
        endcase
    endtask

    task automatic check_dp(input int idx, input logic [W-1:0] exp, input string nm);
        i__dp_idx = IW'(idx);
        #1;
        chk(nm, 64'(o__dp_read), 64'(exp));
    endtask

    task automatic wait_accept();
        logic acc;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            acc = o__rd_req_ready;
            step();
        end
        if (!acc) chk("accept_timeout", 64'd0, 64'd1);
        i__rd_req_valid = 1'b0;
    endtask

    task automatic do_read(input int idx, input logic clr, input int bp,
                           input logic coll, input logic [W-1:0] cdata);
        logic done;
        i__rd_idx        = IW'(idx);
        i__rd_clear      = clr;
        i__rd_req_valid  = 1'b1;
        i__rd_resp_ready = (bp == 0);
        wait_accept();
        if (coll) begin
            i__wr_en   = 1'b1;
            i__wr_idx  = IW'(idx);
            i__wr_data = cdata;
        end
        step();
        for (int k = 0; k < bp; k++) step();
        i__rd_resp_ready = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 10 && !done; k++) begin
            @(negedge clk);
            done = o__rd_resp_valid;
            step();
        end
        if (!done) chk("resp_timeout", 64'd0, 64'd1);
        i__rd_resp_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        i__wr_en = 1'b0; i__wr_idx = '0; i__wr_data = '0; i__dp_idx = '0;
        i__rd_req_valid = 1'b0; i__rd_idx = '0; i__rd_clear = 1'b0;
        i__rd_resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(o__rd_req_ready), 64'd0);
        chk("rst_valid", 64'(o__rd_resp_valid), 64'd0);
        chk("rst_data", 64'(o__rd_resp_data), 64'd0);
        chk("rst_idx", 64'(o__rd_resp_idx), 64'd0);
        chk("rst_err", 64'(o__rd_resp_err), 64'd0);
        @(posedge clk); #1; rst = 1'b0;
        step();

        do_read(3, 1'b0, 0, 1'b0, '0);
        chk("t1_data", 64'(last_data), 64'd0);
        chk("t1_idx", 64'(last_idx), 64'd3);
        chk("t1_err", 64'(last_err), 64'd0);

        i__wr_en = 1'b1; i__wr_idx = 3'd2; i__wr_data = 32'h64;
        step();
        do_read(2, 1'b1, 0, 1'b0, '0);
        chk("t2_data", 64'(last_data), 64'h64);
        do_read(2, 1'b0, 0, 1'b0, '0);
        chk("t2_reread", 64'(last_data), 64'd0);

        i__wr_en = 1'b1; i__wr_idx = 3'd5; i__wr_data = 32'h1234;
        step();
        do_read(5, 1'b1, 0, 1'b1, 32'hAB);
        chk("t3_data", 64'(last_data), 64'hAB);
        check_dp(5, '0, "t3_entry5");

        bg_mode = 2;
        do_read(1, 1'b0, 10, 1'b0, '0);
        bg_mode = 0;
        step();

        do_read(7, 1'b0, 1, 1'b0, '0);
        chk("t5_err", 64'(last_err), 64'd1);
        chk("t5_data", 64'(last_data), 64'd0);
        i__wr_en = 1'b1; i__wr_idx = 3'd6; i__wr_data = 32'hDEAD;
        step();
        check_dp(6, '0, "t5_dp6");

        i__wr_en = 1'b1; i__wr_idx = 3'd4; i__wr_data = 32'h55;
        step();
        i__rd_idx = 3'd4; i__rd_clear = 1'b0; i__rd_req_valid = 1'b1;
        i__rd_resp_ready = 1'b0;
        wait_accept();
        step(); step();
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("t6_valid_drop", 64'(o__rd_resp_valid), 64'd0);
        for (int i = 0; i < N; i++) check_dp(i, '0, "t6_zero");
        @(posedge clk); #1; rst = 1'b0;
        step(); step();
        @(negedge clk);
        chk("t6_ready", 64'(o__rd_req_ready), 64'd1);
        step();

        bg_mode = 1;
        for (int n = 0; n < 40; n++) begin
            do_read($urandom_range(0, 7), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 3), $urandom_range(0, 3) == 0, $urandom);
            repeat ($urandom_range(0, 2)) step();
        end
        bg_mode = 0;
        repeat (3) step();
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/atom_state_reader.md
# atom_state_reader

Register bank holding the persistent state of the MAC stateful atoms, plus the control-plane reader for that state. Data-plane writes arrive every cycle from the atom's `o__write` result with an index. A single-outstanding valid/ready read channel lets the control plane snapshot any entry, with optional clear-on-read. It sits beside the atom pipeline: the atom writes, this block serves reads.

## Interface
- `COUNT_WIDTH`, 32, width of each state entry and of all data ports
- `NUM_ENTRIES`, 8, number of state entries (any value from 2 to 2^`IDX_WIDTH`)
- `IDX_WIDTH`, 3, index width

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `i__wr_en`  in  1  data-plane write strobe
- `i__wr_idx`  in  `IDX_WIDTH`  data-plane write index
- `i__wr_data`  in  `COUNT_WIDTH`  new state value (the atom's `o__write`)
- `i__dp_idx`  in  `IDX_WIDTH`  data-plane read index
- `o__dp_read`  out  `COUNT_WIDTH`  combinational entry[`i__dp_idx`]; 0 if out of range
- `i__rd_req_valid`  in  1  control read request valid
- `o__rd_req_ready`  out  1  request accepted when valid && ready at the clock edge
- `i__rd_idx`  in  `IDX_WIDTH`  entry to read
- `i__rd_clear`  in  1  zero the entry as part of the read
- `o__rd_resp_valid`  out  1  response valid
- `i__rd_resp_ready`  in  1  response consumed when valid && ready at the clock edge
- `o__rd_resp_data`  out  `COUNT_WIDTH`  snapshot value
- `o__rd_resp_idx`  out  `IDX_WIDTH`  index echoed from the request
- `o__rd_resp_err`  out  1  request index was >= `NUM_ENTRIES`

## Operation
- Reset values:
  - all entries 0
  - FSM in IDLE
  - `o__rd_req_ready` 0 while `rst` is high
  - `o__rd_resp_valid`, `o__rd_resp_data`, `o__rd_resp_idx`, `o__rd_resp_err` all 0
- Data-plane writes:
  - when `i__wr_en` is high, entry[`i__wr_idx`] <= `i__wr_data` at the edge
  - independent of FSM state; never stalled
  - writes to an index >= `NUM_ENTRIES` are dropped silently
- FSM states: IDLE -> CAPTURE -> RESP -> IDLE.
  - IDLE:
    - `o__rd_req_ready` = 1 (registered)
    - on request accept, latch idx, clear and err; go to CAPTURE
  - CAPTURE (one cycle): at the edge, load `o__rd_resp_data` with the snapshot and assert `o__rd_resp_valid`; go to RESP.
  - RESP:
    - hold `o__rd_resp_valid`, `o__rd_resp_data`, `o__rd_resp_idx` and `o__rd_resp_err` stable until `i__rd_resp_ready` is high
    - on handshake, drop valid and go to IDLE
- Snapshot rules at the CAPTURE edge:
  - no same-index write: snapshot = entry
  - `i__wr_en` high with `i__wr_idx` equal to the latched index: snapshot = `i__wr_data` (write bypass; newest value wins)
  - clear=1: entry <= 0 even when a same-index write occurs that cycle; the bypassed write value is reported in the snapshot, so no update is lost
  - err=1: snapshot = 0, no clear, `o__rd_resp_err` = 1
- Entries are `COUNT_WIDTH` wide; no arithmetic and no saturation in this block.
- Asserting `rst` mid-transaction aborts the transaction: the response is discarded and all entries are zeroed.

## Timing
- Request accepted at edge T:
  - `o__rd_req_ready` is low from after T until the FSM returns to IDLE
  - `o__rd_resp_valid` is high after edge T+1
- `i__rd_resp_ready` held high: handshake at edge T+2, `o__rd_req_ready` high after T+2, next accept at T+3.
  - Peak read throughput: 1 request per 3 cycles.
- `o__dp_read` is combinational, zero latency. A write at edge E is visible on `o__dp_read` after E; there is no same-cycle bypass on this port.
- Response backpressure is unbounded. Data-plane writes continue during RESP but do not change the held response.
- `i__rd_req_valid` asserted while ready is low has no effect. The requester must hold valid until accepted.

## Test plan
- Reset then read: reset, read idx 3 without clear -> response data 0, idx 3, err 0, valid after T+1.
- Write then read with clear: write 0x64 to idx 2, then read idx 2 with clear=1 -> data 0x64; a second read of idx 2 -> 0.
- Collision: at the CAPTURE edge, write 0xAB to the requested idx 5 with clear=1 -> data 0xAB; entry 5 = 0 afterwards.
- Backpressure: hold `i__rd_resp_ready` low for 10 cycles while writing idx 1 each cycle -> response stays constant; `o__rd_req_ready` stays 0; the handshake completes on release.
- Out of range, `NUM_ENTRIES`=6: read idx 7 -> err 1, data 0; a write to idx 6 leaves `o__dp_read` at 0.
- Reset mid-operation: accept a request, assert `rst` during RESP -> valid drops immediately, all entries 0, and after reset release the FSM is in IDLE with ready 1.
